// File: rtl/uart_rx_controller_pkg.sv
// Shared types and constants for the UART receive controller:
// FSM encoding, receiver status codes and the error-edge detector.
package uart_rx_controller_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } rx_state_t;

    localparam logic [3:0] ERR_NONE   = 4'd0;
    localparam logic [3:0] ERR_PARITY = 4'd1;
    localparam logic [3:0] ERR_FRAME  = 4'd2;

    typedef struct packed {
        logic parity;
        logic frame;
    } err_event_t;

    // A status code counts once on entry; a parity fault that escalates to a
    // stop-bit fault within the same frame counts in both counters.
    function automatic err_event_t detect_err_event(input logic [3:0] prev,
                                                    input logic [3:0] cur);
        err_event_t evt;
        evt.parity = (prev == ERR_NONE) && (cur == ERR_PARITY);
        evt.frame  = (prev != ERR_FRAME) && (cur == ERR_FRAME);
        return evt;
    endfunction

endpackage

// File: rtl/uart_rx_controller_fifo.sv
// Synchronous byte FIFO with combinational head; pointers wrap mod DEPTH.
module uart_byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned COUNT_W = PTR_W + 1;
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: acknowledges completed bytes, buffers them in a FIFO
// for a valid/ready consumer and keeps saturating error/overrun statistics.
module uart_rx_controller
    import uart_rx_controller_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CNT_W        = 8,
    parameter bit          DROP_ON_FULL = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_sent,
    input  logic [3:0]               rx_error,
    output logic                     rx_ack,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         parity_err_cnt,
    output logic [CNT_W-1:0]         frame_err_cnt,
    output logic [CNT_W-1:0]         overrun_cnt
);

    rx_state_t  state;
    rx_state_t  next_state;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       drop_byte;
    logic [3:0] prev_err;
    err_event_t err_evt;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (rx_data),
        .pop       (fifo_pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // With DROP_ON_FULL=0 a full FIFO keeps the FSM in IDLE, retrying every cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (rx_sent && (!fifo_full || DROP_ON_FULL)) next_state = ACK;
            ACK:  if (!rx_sent) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        rx_ack    = (state == ACK);
        fifo_push = (state == IDLE) && rx_sent && !fifo_full;
        drop_byte = (state == IDLE) && rx_sent && fifo_full && DROP_ON_FULL;
    end

    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;
    assign err_evt   = detect_err_event(prev_err, rx_error);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_err       <= ERR_NONE;
            parity_err_cnt <= '0;
            frame_err_cnt  <= '0;
            overrun_cnt    <= '0;
        end else begin
            prev_err <= rx_error;
            if (err_evt.parity && !(&parity_err_cnt)) begin
                parity_err_cnt <= parity_err_cnt + CNT_W'(1);
            end
            if (err_evt.frame && !(&frame_err_cnt)) begin
                frame_err_cnt <= frame_err_cnt + CNT_W'(1);
            end
            if (drop_byte && !(&overrun_cnt)) begin
                overrun_cnt <= overrun_cnt + CNT_W'(1);
            end
        end
    end

endmodule
